id_ex_pipe_reg: RTL and testbench
=================================

# id_ex_pipe_reg

Parametrised decode-to-execute pipeline register for the pipelined OTTER core. It sits between the decode logic (decoder, register file, immediate generator, ALU source muxes) and the execute stage. It carries a configurable number of XLEN-wide payload words plus a control bundle. Compared with the fixed decode register, it adds a valid bit, downstream stall, branch flush, load-use hazard detection with bubble insertion, and saturating hazard/flush counters, all on a single clock edge.

## Interface
- XLEN, 32, width of each payload word and of the instruction
- NUM_WORDS, 9, number of payload words (PC+4, ALU A, ALU B, J/B/I immediates, RS1, RS2, spare)
- CTRL_W, 7, control bundle width (regWrite, memWrite, alu_fun[3:0], rf_wr_sel… packed by the caller; bit 0 = regWrite, bit 1 = memWrite)
- HAZARD_EN, 1, 1 enables load-use detection; 0 ties hazard to 0
- CNT_W, 16, width of each performance counter

Ports:
- REG_CLOCK  in  1  clock; all state updates on the rising edge
- REG_RESET  in  1  synchronous, active-low reset
- DEC_VALID_IN  in  1  decode stage presents a valid instruction
- DEC_IR  in  XLEN  instruction in decode; rs1 = [19:15], rs2 = [24:20], rd = [11:7]
- DEC_WORDS  in  NUM_WORDS*XLEN  payload; word k occupies [k*XLEN +: XLEN]
- DEC_CTRL  in  CTRL_W  control bundle from the decoder
- DEC_MEMREAD_2  in  1  instruction in decode is a load
- EX_FLUSH  in  1  execute resolved a taken branch/jump; squash
- EX_STALL  in  1  downstream cannot accept; hold
- DEC_STALL  out  1  combinational; fetch and decode must hold their contents
- EX_VALID  out  1  execute register holds a real instruction
- EX_IR  out  XLEN  registered instruction
- EX_WORDS  out  NUM_WORDS*XLEN  registered payload
- EX_CTRL  out  CTRL_W  registered control; all-zero whenever EX_VALID=0
- EX_MEMREAD_2  out  1  registered load flag; 0 whenever EX_VALID=0
- EX_RD  out  5  registered rd = EX_IR[11:7]
- HAZ_CNT  out  CNT_W  count of hazard bubbles inserted, saturating
- FLUSH_CNT  out  CNT_W  count of flush cycles, saturating

## Operation
- hazard = HAZARD_EN & DEC_VALID_IN & EX_VALID & EX_MEMREAD_2 & (EX_RD != 0) & (EX_RD == DEC_IR[19:15] | EX_RD == DEC_IR[24:20]). Both fields are compared for every format; this is a deliberately conservative match.
- On each rising edge, exactly one action applies, in this priority order:
  1. REG_RESET=0: every output register and both counters are cleared to 0.
  2. EX_FLUSH=1: load a bubble and increment FLUSH_CNT. Flush wins over EX_STALL and hazard.
  3. EX_STALL=1: hold every EX_* register unchanged.
  4. hazard=1: load a bubble and increment HAZ_CNT.
  5. Otherwise: EX_IR <= DEC_IR, EX_WORDS <= DEC_WORDS, EX_VALID <= DEC_VALID_IN. EX_CTRL and EX_MEMREAD_2 take their inputs if DEC_VALID_IN=1, else 0.
- A bubble sets EX_VALID=0, EX_CTRL=0 and EX_MEMREAD_2=0. EX_IR and EX_WORDS capture the inputs, but their values are don't-care.
- DEC_STALL = ~EX_FLUSH & (EX_STALL | hazard). It is forced to 0 while REG_RESET=0.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- After a hazard bubble, EX_VALID=0, so hazard drops the next cycle and the held instruction advances. Each load-use pair therefore costs exactly one bubble.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on the EX_* outputs after edge N.
- DEC_STALL is purely combinational from the current inputs and EX_* state, in the same cycle.
- Reset value of every output is 0, and DEC_STALL=0 during reset. Reset asserted mid-stall or mid-hazard clears everything on the next edge; no pending state survives.
- Reset release: EX_VALID=0 on the first cycle after release.
- If EX_STALL and hazard are asserted together, the stage holds (no bubble, HAZ_CNT unchanged), and hazard is re-evaluated after the stall clears.
- A flush during an active hazard produces one bubble and increments FLUSH_CNT only.

## Test plan
- Reset: drive REG_RESET=0 for 2 cycles with random inputs -> all outputs 0, DEC_STALL=0; first edge after release with DEC_VALID_IN=1, DEC_IR=0x00500093 -> EX_VALID=1, EX_RD=1.
- Load-use: EX holds lw x5 (EX_MEMREAD_2=1, EX_RD=5); DEC_IR=0x00528333 (add x6,x5,x5) -> DEC_STALL=1, next edge EX_VALID=0, HAZ_CNT=1; following edge EX_IR=0x00528333, EX_VALID=1.
- No false hazard: EX holds lw x0; DEC_IR reads x0 -> DEC_STALL=0, no bubble, HAZ_CNT unchanged.
- Stall hold: EX_STALL=1 for 3 cycles with changing inputs -> EX_* outputs constant, DEC_STALL=1 throughout.
- Flush priority: EX_FLUSH=1 together with EX_STALL=1 and hazard=1 -> EX_VALID=0, EX_CTRL=0, DEC_STALL=0, FLUSH_CNT increments by 1, HAZ_CNT unchanged.
- Saturation: CNT_W=4, 20 flushes -> FLUSH_CNT=15.

Source files
------------

// File: rtl/id_ex_pipe_reg_if.sv
// Decode/execute bundle for id_ex_pipe_reg.
// master = decode+execute side, slave = the pipeline register.
interface id_ex_pipe_reg_if #(
  parameter int XLEN      = 32,
  parameter int NUM_WORDS = 9,
  parameter int CTRL_W    = 7,
  parameter int CNT_W     = 16
);
  logic                      DEC_VALID_IN;
  logic [XLEN-1:0]           DEC_IR;
  logic [NUM_WORDS*XLEN-1:0] DEC_WORDS;
  logic [CTRL_W-1:0]         DEC_CTRL;
  logic                      DEC_MEMREAD_2;
  logic                      EX_FLUSH;
  logic                      EX_STALL;
  logic                      DEC_STALL;
  logic                      EX_VALID;
  logic [XLEN-1:0]           EX_IR;
  logic [NUM_WORDS*XLEN-1:0] EX_WORDS;
  logic [CTRL_W-1:0]         EX_CTRL;
  logic                      EX_MEMREAD_2;
  logic [4:0]                EX_RD;
  logic [CNT_W-1:0]          HAZ_CNT;
  logic [CNT_W-1:0]          FLUSH_CNT;

  modport master (
    output DEC_VALID_IN, DEC_IR, DEC_WORDS,
    output DEC_CTRL, DEC_MEMREAD_2,
    output EX_FLUSH, EX_STALL,
    input  DEC_STALL, EX_VALID, EX_IR,
    input  EX_WORDS, EX_CTRL, EX_MEMREAD_2,
    input  EX_RD, HAZ_CNT, FLUSH_CNT
  );

  modport slave (
    input  DEC_VALID_IN, DEC_IR, DEC_WORDS,
    input  DEC_CTRL, DEC_MEMREAD_2,
    input  EX_FLUSH, EX_STALL,
    output DEC_STALL, EX_VALID, EX_IR,
    output EX_WORDS, EX_CTRL, EX_MEMREAD_2,
    output EX_RD, HAZ_CNT, FLUSH_CNT
  );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// Decode-to-execute register: valid bit, stall, flush, load-use bubble.
// Ports: REG_CLOCK, REG_RESET (sync, active-low), bus (slave modport).
module id_ex_pipe_reg #(
  parameter int XLEN      = 32,
  parameter int NUM_WORDS = 9,
  parameter int CTRL_W    = 7,
  parameter int HAZARD_EN = 1,
  parameter int CNT_W     = 16
) (
  input logic REG_CLOCK,
  input logic REG_RESET,
  id_ex_pipe_reg_if.slave bus
);
  localparam int WW = NUM_WORDS * XLEN;

  logic              valid_q, valid_d;
  logic [XLEN-1:0]   ir_q, ir_d;
  logic [WW-1:0]     words_q, words_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              mr_q, mr_d;
  logic [CNT_W-1:0]  haz_q, haz_d;
  logic [CNT_W-1:0]  fl_q, fl_d;
  logic [4:0]        ex_rd;
  logic              rs_hit;
  logic              hazard;

  assign ex_rd = ir_q[11:7];

  // rs1 and rs2 fields compared for every format (conservative).
  assign rs_hit = (ex_rd == bus.DEC_IR[19:15])
                | (ex_rd == bus.DEC_IR[24:20]);

  assign hazard = (HAZARD_EN != 0)
                & bus.DEC_VALID_IN
                & valid_q & mr_q
                & (ex_rd != 5'd0) & rs_hit;

  always_comb begin
    valid_d = valid_q;
    ir_d    = ir_q;
    words_d = words_q;
    ctrl_d  = ctrl_q;
    mr_d    = mr_q;
    haz_d   = haz_q;
    fl_d    = fl_q;
    if (bus.EX_FLUSH) begin
      valid_d = 1'b0;
      ir_d    = bus.DEC_IR;
      words_d = bus.DEC_WORDS;
      ctrl_d  = '0;
      mr_d    = 1'b0;
      if (fl_q != '1) fl_d = fl_q + 1'b1;
    end else if (bus.EX_STALL) begin
      valid_d = valid_q;
    end else if (hazard) begin
      valid_d = 1'b0;
      ir_d    = bus.DEC_IR;
      words_d = bus.DEC_WORDS;
      ctrl_d  = '0;
      mr_d    = 1'b0;
      if (haz_q != '1) haz_d = haz_q + 1'b1;
    end else begin
      valid_d = bus.DEC_VALID_IN;
      ir_d    = bus.DEC_IR;
      words_d = bus.DEC_WORDS;
      ctrl_d  = bus.DEC_VALID_IN ? bus.DEC_CTRL : '0;
      mr_d    = bus.DEC_VALID_IN & bus.DEC_MEMREAD_2;
    end
  end

  always_ff @(posedge REG_CLOCK) begin
    if (!REG_RESET) begin
      valid_q <= 1'b0;
      ir_q    <= '0;
      words_q <= '0;
      ctrl_q  <= '0;
      mr_q    <= 1'b0;
      haz_q   <= '0;
      fl_q    <= '0;
    end else begin
      valid_q <= valid_d;
      ir_q    <= ir_d;
      words_q <= words_d;
      ctrl_q  <= ctrl_d;
      mr_q    <= mr_d;
      haz_q   <= haz_d;
      fl_q    <= fl_d;
    end
  end

  assign bus.DEC_STALL = REG_RESET & ~bus.EX_FLUSH
                       & (bus.EX_STALL | hazard);

  assign bus.EX_VALID     = valid_q;
  assign bus.EX_IR        = ir_q;
  assign bus.EX_WORDS     = words_q;
  assign bus.EX_CTRL      = ctrl_q;
  assign bus.EX_MEMREAD_2 = mr_q;
  assign bus.EX_RD        = ex_rd;
  assign bus.HAZ_CNT      = haz_q;
  assign bus.FLUSH_CNT    = fl_q;
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg with an expectation queue.
// A second instance with 4-bit counters covers saturation.
module tb_id_ex_pipe_reg;
  localparam int XLEN = 32;
  localparam int NW   = 9;
  localparam int CW   = 7;
  localparam int WW   = NW * XLEN;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  id_ex_pipe_reg_if #(
    .XLEN(XLEN), .NUM_WORDS(NW), .CTRL_W(CW), .CNT_W(16)
  ) bus ();
  id_ex_pipe_reg_if #(
    .XLEN(XLEN), .NUM_WORDS(NW), .CTRL_W(CW), .CNT_W(4)
  ) bus4 ();

  id_ex_pipe_reg #(
    .XLEN(XLEN), .NUM_WORDS(NW), .CTRL_W(CW),
    .HAZARD_EN(1), .CNT_W(16)
  ) dut (
    .REG_CLOCK(clk), .REG_RESET(rst_n), .bus(bus)
  );

  id_ex_pipe_reg #(
    .XLEN(XLEN), .NUM_WORDS(NW), .CTRL_W(CW),
    .HAZARD_EN(1), .CNT_W(4)
  ) dut4 (
    .REG_CLOCK(clk), .REG_RESET(rst_n), .bus(bus4)
  );

  assign bus4.DEC_VALID_IN  = bus.DEC_VALID_IN;
  assign bus4.DEC_IR        = bus.DEC_IR;
  assign bus4.DEC_WORDS     = bus.DEC_WORDS;
  assign bus4.DEC_CTRL      = bus.DEC_CTRL;
  assign bus4.DEC_MEMREAD_2 = bus.DEC_MEMREAD_2;
  assign bus4.EX_FLUSH      = bus.EX_FLUSH;
  assign bus4.EX_STALL      = bus.EX_STALL;

  typedef enum {A_RST, A_LOAD, A_HOLD, A_HAZ, A_FLUSH} act_e;

  typedef struct packed {
    logic          valid;
    logic          known;
    logic [31:0]   ir;
    logic [WW-1:0] words;
    logic [CW-1:0] ctrl;
    logic          mr;
    logic [15:0]   haz;
    logic [15:0]   fl;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int nvec = 0;
  int nmis = 0;

  localparam logic [31:0] ADDI = 32'h00500093;
  localparam logic [31:0] LW5  = 32'h0000A283;
  localparam logic [31:0] ADD6 = 32'h00528333;
  localparam logic [31:0] LW0  = 32'h00002003;
  localparam logic [31:0] ADD0 = 32'h00000033;

  task automatic chk(input string tag,
                     input logic [WW-1:0] obs,
                     input logic [WW-1:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input act_e a, input logic es,
                      input logic v, input logic [31:0] ir,
                      input logic [CW-1:0] ctrl,
                      input logic mr, input logic st,
                      input logic fl);
    logic [WW-1:0] w;
    exp_t g;
    for (int k = 0; k < NW; k++) w[k*XLEN +: XLEN] = $urandom;
    bus.DEC_VALID_IN  = v;
    bus.DEC_IR        = ir;
    bus.DEC_WORDS     = w;
    bus.DEC_CTRL      = ctrl;
    bus.DEC_MEMREAD_2 = mr;
    bus.EX_STALL      = st;
    bus.EX_FLUSH      = fl;
    #1;
    chk("dec_stall", {{(WW-1){1'b0}}, bus.DEC_STALL},
        {{(WW-1){1'b0}}, es});
    case (a)
      A_RST: m = '0;
      A_LOAD: begin
        m.valid = v;
        m.known = 1'b1;
        m.ir    = ir;
        m.words = w;
        m.ctrl  = v ? ctrl : '0;
        m.mr    = v & mr;
      end
      A_HAZ, A_FLUSH: begin
        m.valid = 1'b0;
        m.known = 1'b0;
        m.ctrl  = '0;
        m.mr    = 1'b0;
        if (a == A_HAZ && m.haz != 16'hFFFF) m.haz = m.haz + 1;
        if (a == A_FLUSH && m.fl != 16'hFFFF) m.fl = m.fl + 1;
      end
      default: ;
    endcase
    q.push_back(m);
    @(posedge clk);
    #1;
    g = q.pop_front();
    chk("ex_valid", WW'(bus.EX_VALID), WW'(g.valid));
    chk("ex_ctrl", WW'(bus.EX_CTRL), WW'(g.ctrl));
    chk("ex_memread", WW'(bus.EX_MEMREAD_2), WW'(g.mr));
    chk("haz_cnt", WW'(bus.HAZ_CNT), WW'(g.haz));
    chk("flush_cnt", WW'(bus.FLUSH_CNT), WW'(g.fl));
    if (g.known) begin
      chk("ex_ir", WW'(bus.EX_IR), WW'(g.ir));
      chk("ex_rd", WW'(bus.EX_RD), WW'(g.ir[11:7]));
      chk("ex_words", bus.EX_WORDS, g.words);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    m = '0;
    rst_n = 1'b0;
    repeat (2)
      step(A_RST, 1'b0, 1'b1, $urandom, CW'($urandom),
           1'b1, 1'b1, 1'b0);
    rst_n = 1'b1;
    step(A_LOAD, 1'b0, 1'b1, ADDI, 7'h05, 1'b0, 1'b0, 1'b0);
    // load-use: one bubble then the add advances
    step(A_LOAD, 1'b0, 1'b1, LW5, 7'h01, 1'b1, 1'b0, 1'b0);
    step(A_HAZ, 1'b1, 1'b1, ADD6, 7'h11, 1'b0, 1'b0, 1'b0);
    step(A_LOAD, 1'b0, 1'b1, ADD6, 7'h11, 1'b0, 1'b0, 1'b0);
    // lw x0 never creates a hazard
    step(A_LOAD, 1'b0, 1'b1, LW0, 7'h01, 1'b1, 1'b0, 1'b0);
    step(A_LOAD, 1'b0, 1'b1, ADD0, 7'h21, 1'b0, 1'b0, 1'b0);
    // invalid decode never hazards; ctrl/memread zeroed
    step(A_LOAD, 1'b0, 1'b1, LW5, 7'h01, 1'b1, 1'b0, 1'b0);
    step(A_LOAD, 1'b0, 1'b0, ADD6, 7'h7F, 1'b1, 1'b0, 1'b0);
    // stall hold with changing inputs
    step(A_LOAD, 1'b0, 1'b1, LW5, 7'h03, 1'b1, 1'b0, 1'b0);
    repeat (3)
      step(A_HOLD, 1'b1, 1'b1, $urandom, CW'($urandom),
           1'b1, 1'b1, 1'b0);
    // stall + hazard holds; hazard acts once stall drops
    step(A_HOLD, 1'b1, 1'b1, ADD6, 7'h11, 1'b0, 1'b1, 1'b0);
    step(A_HAZ, 1'b1, 1'b1, ADD6, 7'h11, 1'b0, 1'b0, 1'b0);
    step(A_LOAD, 1'b0, 1'b1, ADD6, 7'h11, 1'b0, 1'b0, 1'b0);
    // flush beats stall and hazard
    step(A_LOAD, 1'b0, 1'b1, LW5, 7'h01, 1'b1, 1'b0, 1'b0);
    step(A_FLUSH, 1'b0, 1'b1, ADD6, 7'h11, 1'b0, 1'b1, 1'b1);
    // reset mid stall/hazard clears everything
    step(A_LOAD, 1'b0, 1'b1, LW5, 7'h01, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    step(A_RST, 1'b0, 1'b1, ADD6, 7'h11, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b1;
    repeat (20)
      step(A_FLUSH, 1'b0, 1'($urandom), $urandom,
           CW'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    chk("flush_cnt_sat4", WW'(bus4.FLUSH_CNT), WW'(4'hF));
    chk("haz_cnt4", WW'(bus4.HAZ_CNT), WW'(4'h0));
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmis);
    $finish;
  end
endmodule
